// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - opcode constants and FSM state type for the arbitrated ALU
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - two-requester operation bus plus result handshake
interface alu_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctr;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctr;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_o;
  logic             res_err;

  modport slave (
    input  req0_valid, req0_ctr, req0_a, req0_b,
    input  req1_valid, req1_ctr, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_o, res_err
  );

  modport master (
    output req0_valid, req0_ctr, req0_a, req0_b,
    output req1_valid, req1_ctr, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_o, res_err
  );
endinterface

// File: rtl/alu_arb_core.sv
// rtl/alu_arb_core.sv - combinational operation unit alu_core; ALU_ARB_ERR_EN enables undefined-opcode flag
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_ctr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_undef
);

  // decode opcode and compute result; add/sub wrap naturally at WIDTH bits
  always_comb begin
    o_res   = '0;
    o_undef = 1'b0;
    case (i_ctr)
      OP_ADD: o_res = i_a + i_b;
      OP_SUB: o_res = i_a - i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_NOT: o_res = ~i_a;
      OP_SHR: o_res = {1'b0, i_a[WIDTH-1:1]};
      OP_SHL: o_res = {i_a[WIDTH-2:0], 1'b0};
      OP_ROR: o_res = {i_a[0], i_a[WIDTH-1:1]};
      OP_ROL: o_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      default: begin
        o_res = '0;
`ifdef ALU_ARB_ERR_EN
        o_undef = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - round-robin two-requester ALU, one op in flight; ALU_ARB_ERR_EN enables res_err
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         ck,
  input  logic         rst,
  alu_arb_if.slave     bus
);

  state_t           r_state;
  state_t           w_next;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             r_last;
  logic [3:0]       r_ctr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_res_id;
  logic             r_err;
  logic [WIDTH-1:0] w_core_res;
  logic             w_core_undef;

  // FSM state register
  always_ff @(posedge ck) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next state and grants; grants only in IDLE and never while reset is held
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last);
          w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last);
          if (w_gnt0 || w_gnt1) w_next = ST_EXEC;
        end
      end
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: if (bus.res_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept       = w_gnt0 || w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.res_valid  = (r_state == ST_DONE);

  // latch the winner's operands; r_last doubles as owner of the in-flight op
  always_ff @(posedge ck) begin
    if (rst) begin
      r_last <= 1'b1;
      r_ctr  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt1;
      r_ctr  <= w_gnt1 ? bus.req1_ctr : bus.req0_ctr;
      r_a    <= w_gnt1 ? bus.req1_a   : bus.req0_a;
      r_b    <= w_gnt1 ? bus.req1_b   : bus.req0_b;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_ctr   (r_ctr),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_res   (w_core_res),
    .o_undef (w_core_undef)
  );

  // register result in EXEC; held untouched through DONE until consumed
  always_ff @(posedge ck) begin
    if (rst) begin
      r_res    <= '0;
      r_res_id <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_res    <= w_core_res;
      r_res_id <= r_last;
      r_err    <= w_core_undef;
    end
  end

  assign bus.res_o  = r_res;
  assign bus.res_id = r_res_id;
`ifdef ALU_ARB_ERR_EN
  assign bus.res_err = r_err;
`else
  assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb with behavioural reference model
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic ck = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   last_gnt;

  alu_arb_if #(.WIDTH(8)) bus ();

  alu_arb #(.WIDTH(8)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: {undefined, result} from the opcode table with plain integer arithmetic
  function automatic logic [8:0] model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, r;
    bit u;
    ua = int'(a);
    ub = int'(b);
    u  = 1'b0;
    r  = 0;
    case (c)
      4'b0000: r = (ua + ub) % 256;
      4'b0001: r = (ua - ub + 256) % 256;
      4'b1001: r = ua | ub;
      4'b1010: r = ua ^ ub;
      4'b1011: r = 255 - ua;
      4'b1100: r = ua / 2;
      4'b1101: r = (ua * 2) % 256;
      4'b1110: r = ua / 2 + (ua % 2) * 128;
      4'b1111: r = (ua * 2) % 256 + ua / 128;
      default: begin r = 0; u = 1'b1; end
    endcase
    return {u, 8'(r)};
  endfunction

  function automatic logic exp_err(input logic u);
`ifdef ALU_ARB_ERR_EN
    return u;
`else
    return 1'b0 & u;
`endif
  endfunction

  task automatic txn(input bit v0, input bit v1,
                     input logic [3:0] c0, input logic [7:0] a0, input logic [7:0] b0,
                     input logic [3:0] c1, input logic [7:0] a1, input logic [7:0] b1,
                     input int hold);
    int win;
    logic [8:0] e;
    @(negedge ck);
    bus.req0_valid = v0; bus.req0_ctr = c0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_ctr = c1; bus.req1_a = a1; bus.req1_b = b1;
    bus.res_ready  = (hold == 0);
    #1;
    if (v0 && v1) win = 1 - last_gnt;
    else if (v1)  win = 1;
    else          win = 0;
    check("idle_req0_ready", 32'(bus.req0_ready), 32'(win == 0));
    check("idle_req1_ready", 32'(bus.req1_ready), 32'(win == 1));
    check("idle_res_valid", 32'(bus.res_valid), 32'd0);
    e = (win == 0) ? model(c0, a0, b0) : model(c1, a1, b1);
    last_gnt = win;
    @(negedge ck);
    bus.req0_ctr = 4'($urandom); bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
    bus.req1_ctr = 4'($urandom); bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
    #1;
    check("exec_res_valid", 32'(bus.res_valid), 32'd0);
    check("exec_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    @(negedge ck);
    #1;
    check("done_res_valid", 32'(bus.res_valid), 32'd1);
    check("done_res_o", 32'(bus.res_o), 32'(e[7:0]));
    check("done_res_id", 32'(bus.res_id), 32'(win));
    check("done_res_err", 32'(bus.res_err), 32'(exp_err(e[8])));
    check("done_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ck);
      bus.req0_a = 8'($urandom);
      bus.req1_a = 8'($urandom);
      #1;
      check("hold_res_valid", 32'(bus.res_valid), 32'd1);
      check("hold_res_o", 32'(bus.res_o), 32'(e[7:0]));
      check("hold_res_id", 32'(bus.res_id), 32'(win));
      check("hold_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    last_gnt = 1;
    bus.req0_valid = 1'b0; bus.req0_ctr = 4'd0; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
    bus.req1_valid = 1'b0; bus.req1_ctr = 4'd0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
    bus.res_ready  = 1'b0;

    // reset state, with both requesters asking while reset is held
    repeat (2) @(negedge ck);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_o", 32'(bus.res_o), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;

    // req0 ADD wraps: F0 + 20 = 10
    txn(1, 0, OP_ADD, 8'hF0, 8'h20, OP_ADD, 8'h00, 8'h00, 0);

    // both valid every slot: grants alternate
    repeat (4) txn(1, 1, OP_XOR, 8'($urandom), 8'($urandom), OP_OR, 8'($urandom), 8'($urandom), 0);

    // req1 ROR held while consumer stalls
    txn(0, 1, OP_ADD, 8'h00, 8'h00, OP_ROR, 8'h81, 8'h00, 5);

    // directed arithmetic and shift corners
    txn(1, 0, OP_SUB, 8'h00, 8'h01, OP_ADD, 8'h00, 8'h00, 0);
    txn(1, 0, OP_SHR, 8'h81, 8'h00, OP_ADD, 8'h00, 8'h00, 0);
    txn(0, 1, OP_ADD, 8'h00, 8'h00, OP_ROL, 8'h81, 8'h00, 1);
    txn(1, 0, OP_NOT, 8'h5A, 8'h00, OP_ADD, 8'h00, 8'h00, 0);
    txn(1, 0, OP_SHL, 8'hC3, 8'h00, OP_ADD, 8'h00, 8'h00, 0);

    // undefined opcode
    txn(1, 0, 4'b0101, 8'hFF, 8'hFF, OP_ADD, 8'h00, 8'h00, 0);
    txn(0, 1, OP_ADD, 8'h00, 8'h00, 4'b0110, 8'h12, 8'h34, 2);

    // reset while an operation is in EXEC
    @(negedge ck);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_ctr = OP_ADD; bus.req1_a = 8'h11; bus.req1_b = 8'h22;
    bus.res_ready  = 1'b1;
    #1;
    check("pre_rst_req1_ready", 32'(bus.req1_ready), 32'd1);
    @(negedge ck);
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    @(negedge ck);
    #1;
    check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("post_rst_res_o", 32'(bus.res_o), 32'd0);
    check("post_rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    last_gnt = 1;
    @(negedge ck);
    #1;
    check("no_pulse_res_valid", 32'(bus.res_valid), 32'd0);
    txn(1, 1, OP_ADD, 8'h01, 8'h02, OP_SUB, 8'h09, 8'h03, 0);

    // randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      int v;
      v = int'($urandom_range(1, 3));
      txn(v[0], v[1],
          4'($urandom), 8'($urandom), 8'($urandom),
          4'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)));
    end

    @(negedge ck);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
